// File: rtl/mxint8_block_dequant.sv
// MXINT8 block dequantizer: buffers one block (E8M0 scale + int8 elements) and
// streams it out as float32, one element per cycle, with valid/ready on both sides.
module mxint8_block_dequant #(
    parameter int BLOCK_SIZE  = 32,
    parameter int ELEM_WIDTH  = 8,
    parameter int SCALE_WIDTH = 8,
    localparam int IDX_W      = $clog2(BLOCK_SIZE)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [SCALE_WIDTH-1:0]        i_scale,
    input  logic signed [ELEM_WIDTH-1:0]  i_mxint8_elements [BLOCK_SIZE],
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [31:0]                   o_float32,
    output logic [IDX_W-1:0]              o_index,
    output logic                          o_last,
    output logic                          o_overflow
);

    localparam int FRAC_BITS = 6;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

    // PEND: last beat still stalled downstream, but the next block is already buffered.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        PEND   = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [SCALE_WIDTH-1:0]        scale_q, scale_d;
    logic signed [ELEM_WIDTH-1:0]  elem_q [BLOCK_SIZE];
    logic signed [ELEM_WIDTH-1:0]  elem_d [BLOCK_SIZE];
    logic [31:0]                   f32_q, f32_d;
    logic                          ovf_q, ovf_d;

    logic                          last_beat;
    logic                          accept;
    logic                          xfer;
    logic [IDX_W-1:0]              idx_nxt;

    // Exact MXINT8 -> float32; returns {overflow, float bits}.
    function automatic logic [32:0] conv(input logic [SCALE_WIDTH-1:0] s,
                                         input logic signed [ELEM_WIDTH-1:0] e);
        logic                 sgn;
        logic [ELEM_WIDTH:0]  e_ext;
        logic [ELEM_WIDTH:0]  mag;
        int                   p;
        logic signed [11:0]   ex;
        logic [22:0]          frac;
        logic [32:0]          res;
        sgn   = e[ELEM_WIDTH-1];
        e_ext = {e[ELEM_WIDTH-1], e};
        mag   = sgn ? (~e_ext + 1'b1) : e_ext;
        p     = 0;
        for (int i = 0; i <= ELEM_WIDTH; i++) begin
            if (mag[i]) p = i;
        end
        ex  = 12'(s) + 12'(p) - 12'(FRAC_BITS);
        res = 33'd0;
        if (s == {SCALE_WIDTH{1'b1}}) begin
            res = {1'b0, 32'h7FC0_0000};
        end else if (e == '0) begin
            res = 33'd0;
        end else if (ex >= 12'sd255) begin
            res = {1'b1, sgn, 31'h7F80_0000};
        end else if (ex >= 12'sd1) begin
            frac = 23'(32'(mag) << (23 - p));
            res  = {1'b0, sgn, ex[7:0], frac};
        end else begin
            frac = 23'(32'(mag) << (32'(s) + 32'd16));
            res  = {1'b0, sgn, 8'h00, frac};
        end
        return res;
    endfunction

    assign last_beat = (idx_q == LAST_IDX);
    assign o_ready   = (state_q == IDLE) || ((state_q == STREAM) && last_beat);
    assign o_valid   = (state_q != IDLE);
    assign o_last    = (state_q != IDLE) && last_beat;
    assign o_float32 = f32_q;
    assign o_overflow = ovf_q;
    assign o_index   = idx_q;
    assign accept    = i_valid && o_ready;
    assign xfer      = o_valid && i_ready;
    assign idx_nxt   = idx_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        scale_d = scale_q;
        elem_d  = elem_q;
        f32_d   = f32_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    scale_d          = i_scale;
                    elem_d           = i_mxint8_elements;
                    idx_d            = '0;
                    {ovf_d, f32_d}   = conv(i_scale, i_mxint8_elements[0]);
                    state_d          = STREAM;
                end
            end
            STREAM: begin
                if (!last_beat) begin
                    if (xfer) begin
                        idx_d          = idx_nxt;
                        {ovf_d, f32_d} = conv(scale_q, elem_q[idx_nxt]);
                    end
                end else if (accept) begin
                    scale_d = i_scale;
                    elem_d  = i_mxint8_elements;
                    if (xfer) begin
                        idx_d          = '0;
                        {ovf_d, f32_d} = conv(i_scale, i_mxint8_elements[0]);
                    end else begin
                        state_d = PEND;
                    end
                end else if (xfer) begin
                    state_d = IDLE;
                end
            end
            PEND: begin
                if (xfer) begin
                    idx_d          = '0;
                    {ovf_d, f32_d} = conv(scale_q, elem_q[0]);
                    state_d        = STREAM;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register stage: buffer, index and the converted output element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            scale_q <= '0;
            f32_q   <= '0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < BLOCK_SIZE; k++) elem_q[k] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            scale_q <= scale_d;
            f32_q   <= f32_d;
            ovf_q   <= ovf_d;
            elem_q  <= elem_d;
        end
    end

endmodule

// File: tb/tb_mxint8_block_dequant.sv
// Bench for mxint8_block_dequant: directed vector table, handshake sequences,
// randomized backpressure against a real-arithmetic reference, and mid-stream reset.
module tb_mxint8_block_dequant;

    localparam int BS = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_valid = 1'b0;
    logic              o_ready;
    logic [7:0]        i_scale = '0;
    logic signed [7:0] i_mxint8_elements [BS];
    logic              o_valid;
    logic              i_ready = 1'b0;
    logic [31:0]       o_float32;
    logic [4:0]        o_index;
    logic              o_last;
    logic              o_overflow;

    int n_chk = 0;
    int n_fail = 0;

    mxint8_block_dequant #(.BLOCK_SIZE(BS), .ELEM_WIDTH(8), .SCALE_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_scale(i_scale), .i_mxint8_elements(i_mxint8_elements),
        .o_valid(o_valid), .i_ready(i_ready), .o_float32(o_float32),
        .o_index(o_index), .o_last(o_last), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          s;
        int          e;
        logic [31:0] f32;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [31:0] f32;
        logic        ovf;
        int          idx;
    } exp_t;

    vec_t vecs [13];
    exp_t expq [$];

    // Reference: value = e * 2^(S-133), encoded to float32 via the exact double value.
    function automatic logic [32:0] ref_conv(input int s, input int e);
        logic        sgn;
        int          m, de, fe;
        real         v;
        logic [63:0] b;
        logic [52:0] full;
        logic [22:0] frac;
        if (s == 255) return {1'b0, 32'h7FC0_0000};
        if (e == 0) return 33'd0;
        sgn  = (e < 0);
        m    = sgn ? -e : e;
        v    = real'(m) * (2.0 ** (real'(s) - 133.0));
        b    = $realtobits(v);
        de   = int'(b[62:52]) - 1023;
        fe   = de + 127;
        if (fe >= 255) return {1'b1, sgn, 31'h7F80_0000};
        if (fe >= 1) return {1'b0, sgn, 8'(fe), b[51:29]};
        full = {1'b1, b[51:0]};
        frac = 23'(full >> (52 - (de + 149)));
        return {1'b0, sgn, 8'h00, frac};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic load_block(input int s, input logic signed [7:0] el [BS]);
        i_scale = 8'(s);
        for (int k = 0; k < BS; k++) i_mxint8_elements[k] = el[k];
    endtask

    logic signed [7:0] blk [BS];
    logic signed [7:0] blk2 [BS];
    logic [32:0]       r;
    logic [31:0]       prev_f32;
    logic [4:0]        prev_idx;
    logic              prev_stall;
    exp_t              ex;
    int                s2;

    initial begin
        vecs[0]  = '{127,   64, 32'h3F80_0000, 1'b0};
        vecs[1]  = '{127,  -64, 32'hBF80_0000, 1'b0};
        vecs[2]  = '{127,    1, 32'h3C80_0000, 1'b0};
        vecs[3]  = '{127,    0, 32'h0000_0000, 1'b0};
        vecs[4]  = '{0,      1, 32'h0001_0000, 1'b0};
        vecs[5]  = '{6,      1, 32'h0040_0000, 1'b0};
        vecs[6]  = '{7,      1, 32'h0080_0000, 1'b0};
        vecs[7]  = '{254, -128, 32'hFF80_0000, 1'b1};
        vecs[8]  = '{254,  127, 32'h7F7E_0000, 1'b0};
        vecs[9]  = '{255, -128, 32'h7FC0_0000, 1'b0};
        vecs[10] = '{255,    0, 32'h7FC0_0000, 1'b0};
        vecs[11] = '{0,   -128, 32'h8080_0000, 1'b0};
        vecs[12] = '{6,     -1, 32'h8040_0000, 1'b0};
        for (int k = 0; k < BS; k++) i_mxint8_elements[k] = '0;

        // Reset state
        #12;
        chk("reset_ready", 32'(o_ready), 32'd1);
        chk("reset_valid", 32'(o_valid), 32'd0);
        chk("reset_last", 32'(o_last), 32'd0);
        chk("reset_ovf", 32'(o_overflow), 32'd0);
        chk("reset_f32", o_float32, 32'h0);
        chk("reset_idx", 32'(o_index), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed conversion table: every beat of a uniform block must match
        foreach (vecs[v]) begin
            @(negedge clk);
            for (int k = 0; k < BS; k++) blk[k] = 8'(vecs[v].e);
            load_block(vecs[v].s, blk);
            i_valid = 1'b1;
            i_ready = 1'b1;
            @(negedge clk);
            i_valid = 1'b0;
            for (int b = 0; b < BS; b++) begin
                chk($sformatf("vec%0d_f32_b%0d", v, b), o_float32, vecs[v].f32);
                if (b == 0 || b == BS - 1)
                    chk($sformatf("vec%0d_ovf_b%0d", v, b), 32'(o_overflow), 32'(vecs[v].ovf));
                @(negedge clk);
            end
            chk($sformatf("vec%0d_idle", v), 32'(o_valid), 32'd0);
        end

        // Ordered ramp block followed by a zero-bubble second block
        for (int k = 0; k < BS; k++) blk[k] = 8'(k - 16);
        for (int k = 0; k < BS; k++) blk2[k] = 8'(k * 7 - 100);
        load_block(127, blk);
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        for (int b = 0; b < BS; b++) begin
            r = ref_conv(127, int'(blk[b]));
            chk($sformatf("ramp_f32_b%0d", b), o_float32, r[31:0]);
            chk($sformatf("ramp_idx_b%0d", b), 32'(o_index), 32'(b));
            chk($sformatf("ramp_last_b%0d", b), 32'(o_last), 32'(b == BS - 1));
            if (b == BS - 1) begin
                chk("ramp_ready_last", 32'(o_ready), 32'd1);
                load_block(130, blk2);
                i_valid = 1'b1;
            end else begin
                chk($sformatf("ramp_ready_b%0d", b), 32'(o_ready), 32'd0);
            end
            @(negedge clk);
        end
        i_valid = 1'b0;
        for (int b = 0; b < BS; b++) begin
            r = ref_conv(130, int'(blk2[b]));
            chk($sformatf("b2_valid_b%0d", b), 32'(o_valid), 32'd1);
            chk($sformatf("b2_f32_b%0d", b), o_float32, r[31:0]);
            chk($sformatf("b2_idx_b%0d", b), 32'(o_index), 32'(b));
            @(negedge clk);
        end
        chk("b2_idle", 32'(o_valid), 32'd0);

        // Randomized traffic with backpressure against the reference scoreboard
        prev_stall = 1'b0;
        prev_f32   = '0;
        prev_idx   = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (prev_stall) begin
                chk("stall_f32", o_float32, prev_f32);
                chk("stall_idx", 32'(o_index), 32'(prev_idx));
            end
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 1) != 0);
            s2 = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) != 0) ? 255 : 254)
                                               : int'($urandom_range(0, 255));
            for (int k = 0; k < BS; k++) blk[k] = 8'($urandom);
            load_block(s2, blk);
            #1;
            if (i_valid && o_ready) begin
                for (int k = 0; k < BS; k++) begin
                    r = ref_conv(s2, int'(blk[k]));
                    expq.push_back('{r[31:0], r[32], k});
                end
            end
            if (o_valid && i_ready) begin
                if (expq.size() == 0) begin
                    chk("rand_unexpected_beat", 32'(o_valid), 32'd0);
                end else begin
                    ex = expq.pop_front();
                    chk("rand_f32", o_float32, ex.f32);
                    chk("rand_ovf", 32'(o_overflow), 32'(ex.ovf));
                    chk("rand_idx", 32'(o_index), 32'(ex.idx));
                    chk("rand_last", 32'(o_last), 32'(ex.idx == BS - 1));
                end
            end
            prev_stall = o_valid && !i_ready;
            prev_f32   = o_float32;
            prev_idx   = o_index;
        end
        // Drain: bounded wait for the scoreboard to empty
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && expq.size() != 0; cyc++) begin
            @(negedge clk);
            #1;
            if (o_valid) begin
                ex = expq.pop_front();
                chk("drain_f32", o_float32, ex.f32);
                chk("drain_idx", 32'(o_index), 32'(ex.idx));
            end
        end
        chk("drain_empty", 32'(expq.size()), 32'd0);
        @(negedge clk);
        chk("drain_idle", 32'(o_valid), 32'd0);

        // Asynchronous reset in the middle of a block
        for (int k = 0; k < BS; k++) blk[k] = 8'(k + 3);
        load_block(120, blk);
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        for (int b = 0; b < 10; b++) @(negedge clk);
        chk("pre_rst_idx", 32'(o_index), 32'd10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_f32", o_float32, 32'h0);
        chk("rst_idx", 32'(o_index), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 32'(o_valid), 32'd0);
        for (int k = 0; k < BS; k++) blk2[k] = 8'(50 - k * 5);
        load_block(140, blk2);
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        for (int b = 0; b < BS; b++) begin
            r = ref_conv(140, int'(blk2[b]));
            chk($sformatf("post_rst_f32_b%0d", b), o_float32, r[31:0]);
            chk($sformatf("post_rst_idx_b%0d", b), 32'(o_index), 32'(b));
            @(negedge clk);
        end
        chk("post_rst_done", 32'(o_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
